// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state types and constants; parity states exist only with UART_PARITY_EN
package uart_pkg;
`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;
`else
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
`endif
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
endpackage

// File: rtl/uart_core_param_bit_timer.sv
// uart_bit_timer: bit-period down-counter, full or half load, tick while at terminal count
module uart_bit_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             half,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt, full, hv;
  // a divisor of 0 behaves as 1, and the half period never drops below 1
  always_comb begin
    full = (baud_div == '0) ? DIV_W'(1) : baud_div;
    hv = ((full >> 1) == '0) ? DIV_W'(1) : (full >> 1);
  end
  // load period-1 and count down, holding at 0
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (load) cnt <= (half ? hv : full) - DIV_W'(1);
    else if (cnt != '0) cnt <= cnt - DIV_W'(1);
  assign tick = (cnt == '0);
endmodule

// File: rtl/uart_core_param.sv
// uart_core_param: parametrised full-duplex UART; UART_PARITY_EN adds a parity bit to both directions
module uart_core_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int DIV_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 rx_en,
  input  logic                 parity_odd,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 uart_tx,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_par_err,
  output logic                 rx_overrun,
  input  logic                 rx_ready,
  output logic                 rx_break
);
  localparam logic [3:0] LAST = 4'(DATA_BITS - 1);
  localparam logic SLAST = 1'(STOP_BITS - 1);
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data
    $error("DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  tx_state_t ts, ts_n;
  rx_state_t rs, rs_n;
  logic [DATA_BITS-1:0] tx_sh, rx_sh;
  logic [3:0] tx_idx, rx_idx;
  logic tx_sidx, t_load, t_tick, tx_last;
  logic [1:0] rx_s;
  logic rxd, r_load, r_half, r_tick, r_perr, r_brk;
`ifdef UART_PARITY_EN
  logic tx_par, rx_pbit;
  assign r_perr = rx_pbit != (^rx_sh ^ (parity_odd == PAR_ODD));
  assign r_brk = !rxd && rx_sh == '0 && !rx_pbit;
`else
  logic unused_par;
  assign unused_par = parity_odd;
  assign r_perr = 1'b0;
  assign r_brk = !rxd && rx_sh == '0;
`endif
  assign tx_last = (tx_sidx == SLAST);
  assign rxd = rx_s[1];
  uart_bit_timer #(.DIV_W(DIV_W)) u_tx_timer (
    .clk(clk), .reset(reset), .load(t_load), .half(1'b0), .baud_div(baud_div), .tick(t_tick)
  );
  uart_bit_timer #(.DIV_W(DIV_W)) u_rx_timer (
    .clk(clk), .reset(reset), .load(r_load), .half(r_half), .baud_div(baud_div), .tick(r_tick)
  );
  // TX state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) ts <= TX_IDLE;
    else ts <= ts_n;
  // TX next state; every bit boundary reloads the timer so a new divisor applies per bit
  always_comb begin
    ts_n = ts;
    t_load = 1'b0;
    case (ts)
      TX_IDLE: if (tx_valid) begin ts_n = TX_START; t_load = 1'b1; end
      TX_START: if (t_tick) begin ts_n = TX_DATA; t_load = 1'b1; end
`ifdef UART_PARITY_EN
      TX_DATA: if (t_tick) begin ts_n = (tx_idx == LAST) ? TX_PARITY : TX_DATA; t_load = 1'b1; end
      TX_PARITY: if (t_tick) begin ts_n = TX_STOP; t_load = 1'b1; end
`else
      TX_DATA: if (t_tick) begin ts_n = (tx_idx == LAST) ? TX_STOP : TX_DATA; t_load = 1'b1; end
`endif
      TX_STOP: if (t_tick) begin ts_n = !tx_last ? TX_STOP : tx_valid ? TX_START : TX_IDLE; t_load = !tx_last || tx_valid; end
      default: ts_n = TX_IDLE;
    endcase
  end
  // TX outputs; ready in the final stop cycle lets the next word follow with no gap
  always_comb begin
    tx_ready = (ts == TX_IDLE) || (ts == TX_STOP && t_tick && tx_last);
    tx_busy = (ts != TX_IDLE);
`ifdef UART_PARITY_EN
    uart_tx = (ts == TX_START) ? 1'b0 : (ts == TX_DATA) ? tx_sh[0] : (ts == TX_PARITY) ? tx_par : 1'b1;
`else
    uart_tx = (ts == TX_START) ? 1'b0 : (ts == TX_DATA) ? tx_sh[0] : 1'b1;
`endif
  end
  // TX datapath: latch word at acceptance, shift LSB first, count stop bits
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tx_sh <= '0;
      tx_idx <= '0;
      tx_sidx <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par <= 1'b0;
`endif
    end else if (tx_valid && tx_ready) begin
      tx_sh <= tx_data;
      tx_idx <= '0;
      tx_sidx <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par <= ^tx_data ^ (parity_odd == PAR_ODD);
`endif
    end else if (t_tick) begin
      if (ts == TX_DATA) begin
        tx_sh <= tx_sh >> 1;
        tx_idx <= tx_idx + 4'd1;
      end
      if (ts == TX_STOP) tx_sidx <= ~tx_sidx;
    end
  // RX synchroniser, idles high
  always_ff @(posedge clk or negedge reset)
    if (!reset) rx_s <= 2'b11;
    else rx_s <= {rx_s[0], uart_rx};
  // RX state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) rs <= RX_IDLE;
    else rs <= rs_n;
  // RX next state: half-bit to start centre, then full bits; all-low frame enters BREAK
  always_comb begin
    rs_n = rs;
    r_load = 1'b0;
    r_half = 1'b0;
    case (rs)
      RX_IDLE: if (!rxd) begin rs_n = RX_START; r_load = 1'b1; r_half = 1'b1; end
      RX_START: if (r_tick) begin rs_n = rxd ? RX_IDLE : RX_DATA; r_load = !rxd; end
`ifdef UART_PARITY_EN
      RX_DATA: if (r_tick) begin rs_n = (rx_idx == LAST) ? RX_PARITY : RX_DATA; r_load = 1'b1; end
      RX_PARITY: if (r_tick) begin rs_n = RX_STOP; r_load = 1'b1; end
`else
      RX_DATA: if (r_tick) begin rs_n = (rx_idx == LAST) ? RX_STOP : RX_DATA; r_load = 1'b1; end
`endif
      RX_STOP: if (r_tick) rs_n = r_brk ? RX_BREAK : RX_IDLE;
      RX_BREAK: if (rxd) rs_n = RX_IDLE;
      default: rs_n = RX_IDLE;
    endcase
  end
  // RX outputs derived from state and the registered valid pulse
  always_comb begin
    rx_break = (rs == RX_BREAK);
    rx_overrun = rx_valid && !rx_ready;
  end
  // RX datapath: shift in at bit centres, publish word and error pulses at stop centre
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rx_sh <= '0;
      rx_idx <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_par_err <= 1'b0;
`ifdef UART_PARITY_EN
      rx_pbit <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_par_err <= 1'b0;
      if (r_tick && rs == RX_START) rx_idx <= '0;
      if (r_tick && rs == RX_DATA) begin
        rx_sh <= {rxd, rx_sh[DATA_BITS-1:1]};
        rx_idx <= rx_idx + 4'd1;
      end
`ifdef UART_PARITY_EN
      if (r_tick && rs == RX_PARITY) rx_pbit <= rxd;
`endif
      if (r_tick && rs == RX_STOP && rx_en) begin
        rx_valid <= 1'b1;
        rx_data <= rx_sh;
        rx_frame_err <= !rxd;
        rx_par_err <= r_perr;
      end
    end
endmodule
